// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   OWN_IF/OWN_D: encoding of the port that owns the outstanding transaction
//   PERF_W      : width of the optional performance counters
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int unsigned PERF_W = 32;

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating event counters for the memory port arbiter.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   if_grant, d_grant : one-cycle strobes for accepted fetch / data requests
//   conflict          : arbitration cycle in which both ports were requesting
//   perf_*            : counter values, reset to 0, stick at all-ones
module mem_arb_perf
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_grant,
  input  logic              d_grant,
  input  logic              conflict,
  output logic [PERF_W-1:0] perf_if_grants,
  output logic [PERF_W-1:0] perf_d_grants,
  output logic [PERF_W-1:0] perf_conflicts
);

  // Each counter increments on its strobe unless already saturated.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_if_grants <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (if_grant && (perf_if_grants != '1))
        perf_if_grants <= perf_if_grants + PERF_W'(1);
      if (d_grant && (perf_d_grants != '1))
        perf_d_grants <= perf_d_grants + PERF_W'(1);
      if (conflict && (perf_conflicts != '1))
        perf_conflicts <= perf_conflicts + PERF_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (read-only) and
// data load/store. One transaction outstanding at a time; the data port has
// priority, with a starvation limiter that forces a fetch grant after
// STARVE_LIM consecutive contested data grants.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   if_req_* / if_addr       : fetch request handshake and address
//   if_resp_valid / if_rdata : fetch response pulse and data
//   d_req_* / d_addr/d_we/d_wdata/d_wstrb : data request handshake and payload
//   d_resp_valid / d_rdata   : load data or store ack (rdata 0) pulse
//   mem_*                    : memory command, driven in the accept cycle
//   mem_rdata                : memory read data, valid MEM_LAT cycles after mem_en
// Optional: define MEM_ARB_PERF_EN to add perf_if_grants, perf_d_grants and
// perf_conflicts counter outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_we,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0]   perf_if_grants,
  output logic [PERF_W-1:0]   perf_d_grants,
  output logic [PERF_W-1:0]   perf_conflicts
`endif
);

  localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIM + 1);

  arb_state_t       state;
  logic             owner;
  logic             owner_st;
  logic [LAT_W-1:0] lat_cnt;
  logic [STV_W-1:0] starve_cnt;

  logic resp_cycle_c;
  logic rsp_c;
  logic arb_open_c;
  logic starved_c;
  logic d_win_c;
  logic d_grant_c;
  logic if_grant_c;

  // Arbitration is open when idle or in the response cycle of the current
  // transaction, which lets MEM_LAT=1 sustain one transaction per cycle.
  assign resp_cycle_c = (state == ARB_WAIT) && (lat_cnt == LAT_W'(MEM_LAT));
  assign rsp_c        = rst && resp_cycle_c;
  assign arb_open_c   = rst && ((state == ARB_IDLE) || resp_cycle_c);
  assign starved_c    = (starve_cnt == STV_W'(STARVE_LIM));
  assign d_win_c      = d_req_valid && !(if_req_valid && starved_c);
  assign d_grant_c    = arb_open_c && d_win_c;
  assign if_grant_c   = arb_open_c && if_req_valid && !d_win_c;

  assign if_req_ready = if_grant_c;
  assign d_req_ready  = d_grant_c;

  // Memory command straight from the winning payload in the accept cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (d_grant_c) begin
      mem_en   = 1'b1;
      mem_we   = d_we;
      mem_addr = d_addr;
      if (d_we) begin
        mem_wdata = d_wdata;
        mem_wstrb = d_wstrb;
      end
    end else if (if_grant_c) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end
  end

  // Response routed to the latched owner; store acks carry zero data.
  assign if_resp_valid = rsp_c && (owner == OWN_IF);
  assign d_resp_valid  = rsp_c && (owner == OWN_D);
  assign if_rdata      = if_resp_valid ? mem_rdata : '0;
  assign d_rdata       = (d_resp_valid && !owner_st) ? mem_rdata : '0;

  // FSM, owner latch, latency counter and starvation counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      owner      <= OWN_IF;
      owner_st   <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      if (d_grant_c || if_grant_c) begin
        state    <= ARB_WAIT;
        owner    <= d_grant_c ? OWN_D : OWN_IF;
        owner_st <= d_grant_c && d_we;
        lat_cnt  <= LAT_W'(1);
      end else if (resp_cycle_c) begin
        state <= ARB_IDLE;
      end else if (state == ARB_WAIT) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end

      // Only contested data grants count toward starvation.
      if (if_grant_c)
        starve_cnt <= '0;
      else if (d_grant_c && if_req_valid && !starved_c)
        starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .if_grant       (if_grant_c),
    .d_grant        (d_grant_c),
    .conflict       (arb_open_c && if_req_valid && d_req_valid),
    .perf_if_grants (perf_if_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_conflicts (perf_conflicts)
  );
`endif

endmodule
